// File: rtl/sqrt_sched.sv
// -----------------------------------------------------------------------------
// sqrt_sched
//
// Round-robin scheduler that shares one square-root engine between two
// requesters. A request is granted in IDLE. The operand is handed to the
// engine in ISSUE. BUSY waits for the engine. The result is then held in RESP
// until the consumer takes it.
//
// Optional feature: define SQRT_SCHED_TIMEOUT_EN to enable the engine-response
// timeout. With the macro, a BUSY phase longer than TO_LIMIT cycles ends with
// Err=1 and Res=0. Without the macro, BUSY waits indefinitely and Err is
// constant 0.
//
// Parameters
//   TO_LIMIT  engine-response timeout in BUSY cycles (timeout build only)
//
// Ports
//   CLK       clock, all state changes on the rising edge
//   RST       synchronous active-high reset
//   Req[1:0]  per-requester request, held until the matching Ack bit
//   Din0/Din1 8-bit operands, stable while the matching Req bit is high
//   Ack[1:0]  one-cycle grant pulse (issued together with Eng_St)
//   Eng_St    one-cycle start pulse to the engine
//   Eng_Din   operand for the engine, held from ISSUE through BUSY
//   Eng_Done  engine completion level, only looked at in BUSY
//   Eng_Sqrt  engine result, valid while Eng_Done is high
//   Vld/Rdy   response handshake
//   Res       4-bit result
//   Tag       index of the requester owning the response
//   Err       response ended by timeout
//   Busy      high whenever the scheduler is not in IDLE
// -----------------------------------------------------------------------------
module sqrt_sched #(
   parameter int TO_LIMIT = 31
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [1:0] Req,
   input  logic [7:0] Din0,
   input  logic [7:0] Din1,
   output logic [1:0] Ack,
   output logic       Eng_St,
   output logic [7:0] Eng_Din,
   input  logic       Eng_Done,
   input  logic [3:0] Eng_Sqrt,
   output logic       Vld,
   input  logic       Rdy,
   output logic [3:0] Res,
   output logic       Tag,
   output logic       Err,
   output logic       Busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        ptr_q,   ptr_d;     // round-robin preference when both request
   logic        owner_q, owner_d;   // requester of the operation in flight
   logic [1:0]  ack_q,   ack_d;
   logic        st_q,    st_d;
   logic [7:0]  din_q,   din_d;
   logic        vld_q,   vld_d;
   logic [3:0]  res_q,   res_d;
   logic        tag_q,   tag_d;
   logic        busy_q,  busy_d;
   logic        grant_idx;

   // A zero limit would make the timeout fire before the engine could answer.
   if (TO_LIMIT < 1) begin : g_to_limit_check
      $error("sqrt_sched: TO_LIMIT must be at least 1");
   end

`ifdef SQRT_SCHED_TIMEOUT_EN
   localparam int               CNT_W    = $clog2(TO_LIMIT + 1);
   // The counter starts at 0 in the first BUSY cycle. The last allowed cycle
   // therefore sees TO_LIMIT-1.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_LIMIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
`endif

   // ---------------------------------------------------------------------------
   // Next-state and registered-output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      ack_d     = 2'b00;
      st_d      = 1'b0;
      din_d     = din_q;
      vld_d     = vld_q;
      res_d     = res_q;
      tag_d     = tag_q;
      grant_idx = ptr_q;
`ifdef SQRT_SCHED_TIMEOUT_EN
      cnt_d     = cnt_q;
      err_d     = err_q;
`endif

      case (state_q)
         IDLE: begin
            // The pointer only matters on contention. A lone request wins
            // outright.
            if (Req[0] && Req[1]) begin
               grant_idx = ptr_q;
            end else begin
               grant_idx = Req[1];
            end

            if (|Req) begin
               owner_d = grant_idx;
               din_d   = grant_idx ? Din1 : Din0;
               ack_d   = grant_idx ? 2'b10 : 2'b01;
               st_d    = 1'b1;
               state_d = ISSUE;
            end
         end

         ISSUE: begin
            // Eng_Done is not looked at here. A level left high by the
            // previous operation must not count as completion.
`ifdef SQRT_SCHED_TIMEOUT_EN
            cnt_d   = '0;
`endif
            state_d = BUSY;
         end

         BUSY: begin
            // A completion in the same cycle as the timeout counts as a
            // normal completion.
            if (Eng_Done) begin
               res_d   = Eng_Sqrt;
               tag_d   = owner_q;
               vld_d   = 1'b1;
               state_d = RESP;
`ifdef SQRT_SCHED_TIMEOUT_EN
               err_d   = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
               res_d   = 4'd0;
               tag_d   = owner_q;
               err_d   = 1'b1;
               vld_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d   = cnt_q + 1'b1;
`endif
            end
         end

         RESP: begin
            if (Rdy) begin
               vld_d   = 1'b0;
               ptr_d   = ~owner_q;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         owner_q <= 1'b0;
         ack_q   <= 2'b00;
         st_q    <= 1'b0;
         din_q   <= 8'd0;
         vld_q   <= 1'b0;
         res_q   <= 4'd0;
         tag_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         ack_q   <= ack_d;
         st_q    <= st_d;
         din_q   <= din_d;
         vld_q   <= vld_d;
         res_q   <= res_d;
         tag_q   <= tag_d;
         busy_q  <= busy_d;
      end
   end

`ifdef SQRT_SCHED_TIMEOUT_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign Err = err_q;
`else
   assign Err = 1'b0;
`endif

   assign Ack     = ack_q;
   assign Eng_St  = st_q;
   assign Eng_Din = din_q;
   assign Vld     = vld_q;
   assign Res     = res_q;
   assign Tag     = tag_q;
   assign Busy    = busy_q;

endmodule

// File: tb/tb_sqrt_sched.sv
module tb_sqrt_sched;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [1:0] Req;
   logic [7:0] Din0 = 8'd0, Din1 = 8'd0;
   logic [1:0] Ack;
   logic       Eng_St;
   logic [7:0] Eng_Din;
   logic       Eng_Done = 1'b0;
   logic [3:0] Eng_Sqrt = 4'd0;
   logic       Vld;
   logic       Rdy = 1'b0;
   logic [3:0] Res;
   logic       Tag;
   logic       Err;
   logic       Busy;

   assign Req = {req1, req0};

   sqrt_sched #(.TO_LIMIT(31)) dut (
      .CLK(CLK), .RST(RST), .Req(Req), .Din0(Din0), .Din1(Din1), .Ack(Ack),
      .Eng_St(Eng_St), .Eng_Din(Eng_Din), .Eng_Done(Eng_Done), .Eng_Sqrt(Eng_Sqrt),
      .Vld(Vld), .Rdy(Rdy), .Res(Res), .Tag(Tag), .Err(Err), .Busy(Busy)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int res;
      int tag;
      int err;
   } exp_t;

   exp_t sb_q[$];
   int   grant_log[$];
   bit   ptr_m     = 1'b0;   // reference round-robin preference
   bit   expect_to = 1'b0;   // next grant is expected to time out
   int   eng_delay = 1;      // -1: never answer, -2: random 0..4
   int   rdy_mode  = 0;      // 0: always ready, 1: random, 2: never ready

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic int isqrt(input int x);
      int r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
      return r;
   endfunction

   // Engine model: takes the start seen in ISSUE and drops Done on the next
   // edge. It raises Done with the new result after the chosen delay. Done then
   // stays high until the next start.
   initial begin
      bit pend = 1'b0;
      int cnt  = 0;
      int val  = 0;
      forever begin
         @(negedge CLK);
         if (Eng_St === 1'b1) begin
            pend = 1'b1;
            cnt  = (eng_delay == -2) ? int'($urandom_range(4, 0)) : eng_delay;
            val  = isqrt(int'(Eng_Din));
         end
         @(posedge CLK);
         #1;
         if (pend) begin
            if (cnt < 0) begin
               Eng_Done = 1'b0;
            end else if (cnt == 0) begin
               Eng_Done = 1'b1;
               Eng_Sqrt = 4'(val);
               pend     = 1'b0;
            end else begin
               Eng_Done = 1'b0;
               cnt--;
            end
         end
      end
   end

   // Consumer ready driver
   initial begin
      forever begin
         @(posedge CLK);
         #2;
         case (rdy_mode)
            0:       Rdy = 1'b1;
            1:       Rdy = ($urandom_range(2, 0) != 0);
            default: Rdy = 1'b0;
         endcase
      end
   end

   // Predictor and monitor. A grant pushes the expected response. A completed
   // handshake pops it and compares.
   initial begin
      logic       pv = 1'b0, pr = 1'b0;
      logic [3:0] pres = 4'd0;
      logic       ptag = 1'b0, perr = 1'b0;
      logic [1:0] snap_req = 2'b00;
      logic [7:0] snap0 = 8'd0, snap1 = 8'd0;
      exp_t       e;
      int         w;
      int         opv;
      forever begin
         @(negedge CLK);
         if (RST === 1'b1) begin
            sb_q.delete();
            ptr_m = 1'b0;
            pv    = 1'b0;
         end else begin
            check("st_without_ack", {31'd0, Eng_St & (Ack == 2'b00)}, 0);
            if (Ack !== 2'b00) begin
               check("ack_had_req", {31'd0, |snap_req}, 1);
               w   = (snap_req == 2'b11) ? int'(ptr_m) : int'(snap_req[1]);
               opv = (w == 1) ? int'(snap1) : int'(snap0);
               check("ack_grant", Ack, (w == 1) ? 2'b10 : 2'b01);
               check("issue_eng_st", Eng_St, 1);
               check("issue_eng_din", Eng_Din, opv);
               check("issue_busy", Busy, 1);
               e.tag = w;
               e.err = expect_to ? 1 : 0;
               e.res = expect_to ? 0 : isqrt(opv);
               sb_q.push_back(e);
               grant_log.push_back(w);
            end
            if (Vld === 1'b1) begin
               check("vld_no_start", {Ack, Eng_St}, 0);
               check("vld_busy", Busy, 1);
               if (pv === 1'b1 && pr !== 1'b1)
                  check("resp_stable", {Res, Tag, Err}, {pres, ptag, perr});
               if (Rdy === 1'b1) begin
                  check("resp_expected", {31'd0, sb_q.size() != 0}, 1);
                  if (sb_q.size() != 0) begin
                     e = sb_q.pop_front();
                     check("resp_res", Res, e.res);
                     check("resp_tag", Tag, e.tag);
                     check("resp_err", Err, e.err);
                     ptr_m = (e.tag == 0);
                  end
               end
            end
            pv = Vld; pr = Rdy; pres = Res; ptag = Tag; perr = Err;
         end
         snap_req = Req; snap0 = Din0; snap1 = Din1;
      end
   end

   task automatic check_reset_outputs(input string nm);
      check({nm, "_ack"},  Ack, 0);
      check({nm, "_st"},   Eng_St, 0);
      check({nm, "_din"},  Eng_Din, 0);
      check({nm, "_vld"},  Vld, 0);
      check({nm, "_res"},  Res, 0);
      check({nm, "_tag"},  Tag, 0);
      check({nm, "_err"},  Err, 0);
      check({nm, "_busy"}, Busy, 0);
   endtask

   task automatic apply_reset(input string nm);
      @(posedge CLK); #1; RST = 1'b1;
      @(posedge CLK); #1; RST = 1'b0;
      @(negedge CLK);
      check_reset_outputs(nm);
   endtask

   task automatic wait_ack(input int idx, input string nm);
      int t = 0;
      do begin @(negedge CLK); t++; end while (Ack[idx] !== 1'b1 && t < 400);
      check(nm, Ack[idx], 1);
   endtask

   task automatic do_req(input int idx, input int nops, input int maxgap, input int fixed_val);
      int         gap;
      logic [7:0] v;
      @(posedge CLK); #1;
      for (int k = 0; k < nops; k++) begin
         gap = $urandom_range(maxgap, 0);
         repeat (gap) begin @(posedge CLK); #1; end
         v = (fixed_val < 0) ? 8'($urandom) : 8'(fixed_val);
         if (idx == 0) begin Din0 = v; req0 = 1'b1; end
         else          begin Din1 = v; req1 = 1'b1; end
         wait_ack(idx, $sformatf("ack_wait_r%0d", idx));
         @(posedge CLK); #1;
         if (idx == 0) req0 = 1'b0; else req1 = 1'b0;
      end
   endtask

   task automatic drain();
      int t = 0;
      while ((sb_q.size() != 0 || Vld === 1'b1) && t < 1000) begin
         @(negedge CLK);
         t++;
      end
      check("drain_pending", sb_q.size(), 0);
   endtask

   task automatic wait_vld(output int t);
      t = 0;
      do begin @(negedge CLK); t++; end while (Vld !== 1'b1 && t < 100);
   endtask

   initial begin
      int t;

      // Reset state
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check_reset_outputs("rst_init");
      @(posedge CLK); #1; RST = 1'b0;

      // Single request, engine answers two cycles after start
      rdy_mode  = 0;
      eng_delay = 1;
      @(posedge CLK); #1; Din0 = 8'd49; req0 = 1'b1;
      t = 0;
      do begin @(negedge CLK); t++; end while (Ack === 2'b00 && t < 20);
      check("d49_ack_latency", t, 2);
      check("d49_ack", Ack, 2'b01);
      check("d49_eng_din", Eng_Din, 49);
      @(posedge CLK); #1; req0 = 1'b0;
      wait_vld(t);
      check("d49_vld_latency", t, 3);
      check("d49_res", Res, 7);
      check("d49_tag", Tag, 0);
      check("d49_err", Err, 0);
      check("d49_din_hold", Eng_Din, 49);
      drain();

      // Both requesting from reset: alternating grants 0,1,0
      apply_reset("rst_rr");
      grant_log.delete();
      fork
         do_req(0, 2, 0, 16);
         do_req(1, 2, 0, 81);
      join
      drain();
      check("rr_order_len", grant_log.size(), 4);
      if (grant_log.size() >= 3) begin
         check("rr_grant0", grant_log[0], 0);
         check("rr_grant1", grant_log[1], 1);
         check("rr_grant2", grant_log[2], 0);
      end

      // Consumer stalls with another request pending
      rdy_mode  = 2;
      eng_delay = 0;
      @(posedge CLK); #1; Din0 = 8'd9; req0 = 1'b1;
      wait_ack(0, "stall_ack0");
      @(posedge CLK); #1; req0 = 1'b0;
      wait_vld(t);
      check("stall_vld_seen", Vld, 1);
      @(posedge CLK); #1; Din1 = 8'd144; req1 = 1'b1;
      repeat (5) begin
         @(negedge CLK);
         check("stall_vld_held", Vld, 1);
         check("stall_no_ack", Ack, 0);
         check("stall_no_start", Eng_St, 0);
      end
      @(posedge CLK); #1; rdy_mode = 0;
      t = 0;
      do begin @(negedge CLK); t++; end while (Ack[1] !== 1'b1 && t < 20);
      check("stall_next_ack_latency", t, 3);
      @(posedge CLK); #1; req1 = 1'b0;
      drain();

      // Randomized traffic
      rdy_mode  = 1;
      eng_delay = -2;
      fork
         do_req(0, 25, 3, -1);
         do_req(1, 25, 3, -1);
      join
      drain();

      // Reset in BUSY: no response, pointer back to 0, stale Done ignored
      rdy_mode  = 0;
      eng_delay = 0;
      @(posedge CLK); #1; Din0 = 8'd100; req0 = 1'b1;
      wait_ack(0, "rstb_ack0");
      @(posedge CLK); #1; req0 = 1'b0;
      drain();
      eng_delay = 6;
      @(posedge CLK); #1; Din1 = 8'd225; req1 = 1'b1;
      wait_ack(1, "rstb_ack1");
      @(posedge CLK); #1; req1 = 1'b0;
      repeat (2) @(negedge CLK);
      apply_reset("rst_busy");
      repeat (12) begin
         @(negedge CLK);
         check("rstb_no_resp", Vld, 0);
      end
      eng_delay = 0;
      grant_log.delete();
      fork
         do_req(0, 1, 0, 36);
         do_req(1, 1, 0, 25);
      join
      drain();
      check("rstb_ptr_winner", (grant_log.size() != 0) ? grant_log[0] : -1, 0);

`ifdef SQRT_SCHED_TIMEOUT_EN
      // Engine never answers: timeout after 31 BUSY cycles
      expect_to = 1'b1;
      eng_delay = -1;
      @(posedge CLK); #1; Din0 = 8'd200; req0 = 1'b1;
      wait_ack(0, "to_ack");
      @(posedge CLK); #1; req0 = 1'b0; expect_to = 1'b0;
      wait_vld(t);
      check("to_vld_latency", t, 32);
      check("to_err", Err, 1);
      check("to_res", Res, 0);
      drain();
      // Done arrives in the timeout cycle: normal completion
      eng_delay = 30;
      @(posedge CLK); #1; Din0 = 8'd200; req0 = 1'b1;
      wait_ack(0, "to_edge_ack");
      @(posedge CLK); #1; req0 = 1'b0;
      wait_vld(t);
      check("to_edge_latency", t, 32);
      check("to_edge_err", Err, 0);
      check("to_edge_res", Res, 14);
      drain();
`endif

      check("sb_empty_end", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sqrt_sched.md
SQRT_SCHED -- requirements
Module: sqrt_sched

Interface
REQ-001 The block SHALL have parameter TO_LIMIT, default 31, the engine-response timeout in cycles (used only under SQRT_SCHED_TIMEOUT_EN).
REQ-002 Port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-003 Port RST  input  1  reset, synchronous and active-high.
REQ-004 Port Req  input  2  request per requester; bit i is held high until Ack[i].
REQ-005 Port Din0  input  8  operand of requester 0; stable while Req[0] is high.
REQ-006 Port Din1  input  8  operand of requester 1; stable while Req[1] is high.
REQ-007 Port Ack  output  2  one-cycle grant or accept pulse per requester.
REQ-008 Port Eng_St  output  1  one-cycle start pulse to the shared square-root engine.
REQ-009 Port Eng_Din  output  8  operand presented to the engine.
REQ-010 Port Eng_Done  input  1  engine done; may stay high until the next start.
REQ-011 Port Eng_Sqrt  input  4  engine result, valid when Eng_Done is high.
REQ-012 Port Vld  output  1  response valid.
REQ-013 Port Rdy  input  1  response consumer ready.
REQ-014 Port Res  output  4  response result.
REQ-015 Port Tag  output  1  index of the requester that owns the response.
REQ-016 Port Err  output  1  response aborted by timeout; always 0 without the macro.
REQ-017 Port Busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, BUSY and RESP, and all outputs SHALL be registered.
REQ-019 IDLE: with any Req bit high, the block SHALL grant one requester, latch its operand and owner index, and go to ISSUE.
REQ-019a With no Req bit high, the FSM SHALL stay in IDLE.
REQ-020 Arbitration SHALL be round-robin via a 1-bit pointer: with both Req bits high, the pointer's requester wins.
REQ-020a A lone request SHALL win regardless of the pointer.
REQ-021 On every completed response (Vld&&Rdy), the pointer SHALL become the index of the requester not just served.
REQ-022 ISSUE lasts exactly one cycle: Ack[owner]=1, Eng_St=1, Eng_Din=latched operand; next state is BUSY.
REQ-023 Eng_Din SHALL hold the latched operand from ISSUE until the FSM leaves BUSY.
REQ-024 Eng_Done SHALL be ignored outside BUSY, so a level still high from the previous operation is never taken as completion.
REQ-025 BUSY: on Eng_Done=1, the block SHALL capture Eng_Sqrt into Res and go to RESP; otherwise it stays in BUSY.
REQ-026 RESP: Vld=1 with Res, Tag and Err held stable until Rdy=1.
REQ-026a The cycle with Vld&&Rdy SHALL be the last RESP cycle; next state is IDLE and Vld=0.
REQ-027 Requests arriving while Busy=1 SHALL be held pending and not acked; Req changes during Busy SHALL not affect the current operation.
REQ-028 Minimum latency from Req rise to Vld with immediate Eng_Done and Rdy: Ack and Eng_St 1 cycle after the Req-sampling edge; Vld 1 cycle after Eng_Done is sampled in BUSY.
REQ-029 The block SHALL start no new operation while Vld=1; Ack SHALL never have both bits high.

Reset
REQ-030 With RST=1 at a rising CLK edge, the block SHALL enter IDLE with pointer=0 and all outputs 0: Ack, Eng_St, Eng_Din, Vld, Res, Tag, Err, Busy.
REQ-031 RST asserted mid-operation SHALL abandon the operation without emitting a response; a later Eng_Done SHALL be ignored per REQ-024.
REQ-032 RST SHALL take priority over every other event in the same cycle.

Configuration
REQ-033 With macro SQRT_SCHED_TIMEOUT_EN defined, a cycle counter SHALL clear on entry to BUSY and increment each BUSY cycle without Eng_Done.
REQ-033a When the count reaches TO_LIMIT, the block SHALL go to RESP with Err=1 and Res=0.
REQ-033b Eng_Done and timeout in the same cycle SHALL be treated as a normal completion (Err=0).
REQ-034 With SQRT_SCHED_TIMEOUT_EN undefined, no counter SHALL exist, BUSY SHALL wait for Eng_Done indefinitely, and Err SHALL be tied to 0.

Verification
REQ-035 Req=01, Din0=49; engine Done with Sqrt=7 two cycles after Eng_St; Rdy=1 -> Ack=01 for one cycle, Eng_Din=49, then Vld=1, Res=7, Tag=0, Err=0.
REQ-036 Req=11 held for three operations from reset, Din0=16, Din1=81 -> grants in order 0,1,0 with Tags 0,1,0 and Res 4,9,4.
REQ-037 Rdy=0 for 5 cycles after Vld rises, with Req[1] pending -> Vld, Res and Tag stable, no Ack, no Eng_St until the cycle after Vld&&Rdy.
REQ-038 Eng_Done held high from the previous operation through ISSUE -> no completion until Eng_Done is sampled high in BUSY.
REQ-039 RST pulse while in BUSY -> all outputs 0 next cycle, no Vld, pointer=0; a subsequent stale Eng_Done produces no response.
REQ-040 With SQRT_SCHED_TIMEOUT_EN defined and TO_LIMIT=31, Eng_Done never asserted -> Vld=1, Err=1, Res=0 after 31 BUSY cycles; Eng_Done in that same cycle -> Err=0.
